// File: rtl/boot_power_seq.sv
// boot_power_seq: power-up, USB-attach and warmboot sequencer for iCE40 bootloader boards
module boot_power_seq #(
  parameter int         NUM_RAILS     = 2,
  parameter int         CLK_DELAY     = 48000,
  parameter int         RAIL_DELAY    = 4800,
  parameter int         BOOT_DELAY    = 480000,
  parameter logic [1:0] DEFAULT_IMAGE = 2'b01
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  input  logic                 ext_clk_ok,
  input  logic                 boot_req,
  input  logic [1:0]           image_sel,
  input  logic                 image_valid,
  output logic                 clk48_en,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 usb_pu,
  output logic                 ready,
  output logic                 fault,
  output logic                 warmboot_boot,
  output logic [1:0]           warmboot_s
);
  localparam int MAXD = CLK_DELAY > RAIL_DELAY ? (CLK_DELAY > BOOT_DELAY ? CLK_DELAY : BOOT_DELAY)
                                               : (RAIL_DELAY > BOOT_DELAY ? RAIL_DELAY : BOOT_DELAY);
  localparam int CW = $clog2(MAXD) + 1;
  localparam int IW = $clog2(NUM_RAILS + 1);
  typedef enum logic [2:0] {IDLE, CLKWAIT, RAMP, RUN, DETACH, RAMPDN, BOOT, FAULT} state_t;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_ok1, r_ok2, r_req_d, r_pend;
  logic                 r_clk_en, r_pu, r_ready, r_fault, r_boot;
  logic [NUM_RAILS-1:0] r_rail;
  logic [1:0]           r_s;
  logic                 w_edge, w_exp, w_take;
  assign w_edge = boot_req & ~r_req_d;
  assign w_exp  = r_cnt == CW'(1);
  // Only the first edge seen before shutdown starts is honoured; FAULT never accepts one.
  assign w_take = w_edge & ~r_pend & (r_state inside {IDLE, CLKWAIT, RAMP, RUN});
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_ok1    <= 1'b0;
      r_ok2    <= 1'b0;
      r_req_d  <= 1'b0;
      r_pend   <= 1'b0;
      r_clk_en <= 1'b0;
      r_rail   <= '0;
      r_pu     <= 1'b0;
      r_ready  <= 1'b0;
      r_fault  <= 1'b0;
      r_boot   <= 1'b0;
      r_s      <= DEFAULT_IMAGE;
    end else begin
      r_ok1   <= ext_clk_ok;
      r_ok2   <= r_ok1;
      r_req_d <= boot_req;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_take) begin
        r_pend <= 1'b1;
        r_s    <= image_valid ? image_sel : DEFAULT_IMAGE;
      end
      case (r_state)
        IDLE: begin
          r_state  <= CLKWAIT;
          r_clk_en <= 1'b1;
          r_cnt    <= CW'(CLK_DELAY);
        end
        CLKWAIT: if (w_exp) begin
          if (r_ok2) begin
            r_state <= RAMP;
            r_rail  <= NUM_RAILS'(1);
            r_idx   <= IW'(1);
            r_cnt   <= CW'(RAIL_DELAY);
          end else begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end
        end
        RAMP: if (w_exp) begin
          if (r_idx == IW'(NUM_RAILS)) begin
            if (r_pend || w_edge) begin
              r_state <= DETACH;
              r_cnt   <= CW'(BOOT_DELAY);
            end else begin
              r_state <= RUN;
              r_pu    <= 1'b1;
              r_ready <= 1'b1;
            end
          end else begin
            r_rail <= (r_rail << 1) | NUM_RAILS'(1);
            r_idx  <= r_idx + 1'b1;
            r_cnt  <= CW'(RAIL_DELAY);
          end
        end
        RUN: if (w_edge) begin
          r_state <= DETACH;
          r_pu    <= 1'b0;
          r_ready <= 1'b0;
          r_cnt   <= CW'(BOOT_DELAY);
        end
        DETACH: if (w_exp) begin
          r_state <= RAMPDN;
          r_rail  <= r_rail >> 1;
          r_idx   <= r_idx - 1'b1;
          r_cnt   <= CW'(RAIL_DELAY);
        end
        RAMPDN: if (w_exp) begin
          if (r_idx == '0) begin
            r_state <= BOOT;
            r_boot  <= 1'b1;
          end else begin
            r_rail <= r_rail >> 1;
            r_idx  <= r_idx - 1'b1;
            r_cnt  <= CW'(RAIL_DELAY);
          end
        end
        default: ;
      endcase
    end
  end
  assign clk48_en      = r_clk_en;
  assign rail_en       = r_rail;
  assign usb_pu        = r_pu;
  assign ready         = r_ready;
  assign fault         = r_fault;
  assign warmboot_boot = r_boot;
  assign warmboot_s    = r_s;
endmodule

// File: tb/tb_boot_power_seq.sv
// tb_boot_power_seq: randomized and directed checks against an edge-timing reference model
module tb_boot_power_seq;
  localparam int N = 2, C = 4, R = 3, B = 5, TR = C + N * R;
  localparam logic [1:0] DEF = 2'b01;
  logic clk_48mhz = 1'b0, reset = 1'b1, ext_clk_ok = 1'b0, boot_req = 1'b0, image_valid = 1'b0;
  logic [1:0] image_sel = 2'b00;
  logic clk48_en, usb_pu, ready, fault, warmboot_boot;
  logic [N-1:0] rail_en;
  logic [1:0] warmboot_s;
  logic [8:0] obs, exp_v;
  int checks = 0, failures = 0, n = -1, q1 = -1, q2 = -1;
  logic [1:0] sel1 = 2'b00, sel2 = 2'b00;
  logic v1 = 1'b0, v2 = 1'b0;

  boot_power_seq #(.NUM_RAILS(N), .CLK_DELAY(C), .RAIL_DELAY(R), .BOOT_DELAY(B), .DEFAULT_IMAGE(DEF)) dut (
    .clk_48mhz(clk_48mhz), .reset(reset), .ext_clk_ok(ext_clk_ok), .boot_req(boot_req),
    .image_sel(image_sel), .image_valid(image_valid), .clk48_en(clk48_en), .rail_en(rail_en),
    .usb_pu(usb_pu), .ready(ready), .fault(fault), .warmboot_boot(warmboot_boot), .warmboot_s(warmboot_s));

  always #5 clk_48mhz = ~clk_48mhz;
  assign obs = {clk48_en, rail_en, usb_pu, ready, fault, warmboot_boot, warmboot_s};

  // Expected outputs after edge k, from the timing table: rails on = ramp-up steps minus ramp-down steps.
  function automatic logic [8:0] model(int k, bit ok, int eq, logic [1:0] img);
    int up, dn, eb;
    logic [1:0] s;
    logic [N-1:0] rails;
    s = (eq >= 0 && k >= eq && (ok || eq <= C)) ? img : DEF;
    if (!ok) return {1'b1, {N{1'b0}}, 1'b0, 1'b0, k >= C, 1'b0, s};
    up = (k < C) ? 0 : (((k - C) / R + 1) > N ? N : (k - C) / R + 1);
    eb = (eq < 0) ? (1 << 30) : (eq > TR ? eq : TR);
    dn = (k < eb + B) ? 0 : (((k - eb - B) / R + 1) > N ? N : (k - eb - B) / R + 1);
    rails = N'((1 << (up - dn)) - 1);
    return {1'b1, rails, k >= TR && k < eb, k >= TR && k < eb, 1'b0, k >= eb + B + N * R, s};
  endfunction

  task automatic tick();
    boot_req    = (n + 1 == q1) || (n + 1 == q2);
    image_sel   = (n + 1 == q2) ? sel2 : sel1;
    image_valid = (n + 1 == q2) ? v2 : v1;
    @(posedge clk_48mhz);
    #1;
    n++;
  endtask

  task automatic start(bit ok);
    ext_clk_ok = ok;
    reset = 1'b1;
    boot_req = 1'b0;
    repeat (3) @(posedge clk_48mhz);
    #1;
    reset = 1'b0;
    n = -1;
  endtask

  task automatic test_reset();
    ext_clk_ok = 1'b1;
    boot_req = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk_48mhz);
    #1;
    checks++;
    if (obs !== {1'b0, {N{1'b0}}, 4'b0000, DEF}) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b", obs, {1'b0, {N{1'b0}}, 4'b0000, DEF});
    end
  endtask

  task automatic test_powerup();
    q1 = -1; q2 = -1; sel1 = 2'b00; v1 = 1'b0;
    start(1'b1);
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_v = model(n, 1'b1, -1, DEF);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL powerup n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_fault();
    q1 = 20; q2 = 50; sel1 = 2'b11; v1 = 1'b1; sel2 = 2'b10; v2 = 1'b1;
    start(1'b0);
    for (int i = 0; i < 104; i++) begin
      tick();
      exp_v = model(n, 1'b0, q1, 2'b11);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL fault n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_run_boot();
    q1 = 15; q2 = -1; sel1 = 2'b11; v1 = 1'b1;
    start(1'b1);
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_v = model(n, 1'b1, 15, 2'b11);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL run_boot n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_pending();
    q1 = 5; q2 = -1; sel1 = 2'b10; v1 = 1'b0;
    start(1'b1);
    for (int i = 0; i < 26; i++) begin
      tick();
      exp_v = model(n, 1'b1, 5, DEF);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL pending n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_second_req();
    q1 = 15; q2 = 17; sel1 = 2'b11; v1 = 1'b1; sel2 = 2'b10; v2 = 1'b1;
    start(1'b1);
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_v = model(n, 1'b1, 15, 2'b11);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL second_req n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_rampdn();
    q1 = 15; q2 = -1; sel1 = 2'b11; v1 = 1'b1;
    start(1'b1);
    while (n < 21) tick();
    reset = 1'b1;
    boot_req = 1'b0;
    @(posedge clk_48mhz);
    #1;
    checks++;
    if (obs !== {1'b0, {N{1'b0}}, 4'b0000, DEF}) begin
      failures++;
      $display("FAIL reset_rampdn got=%b exp=%b", obs, {1'b0, {N{1'b0}}, 4'b0000, DEF});
    end
    reset = 1'b0;
    n = -1; q1 = -1;
    for (int i = 0; i < 14; i++) begin
      tick();
      exp_v = model(n, 1'b1, -1, DEF);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL repowerup n=%0d got=%b exp=%b", n, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [1:0] img;
    for (int t = 0; t < 24; t++) begin
      ok   = $urandom_range(0, 4) != 0;
      q1   = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 25)) : -1;
      q2   = (q1 >= 0) ? q1 + int'($urandom_range(2, 10)) : -1;
      sel1 = 2'($urandom_range(0, 3));
      v1   = 1'($urandom_range(0, 1));
      sel2 = 2'($urandom_range(0, 3));
      v2   = 1'($urandom_range(0, 1));
      img  = v1 ? sel1 : DEF;
      start(ok);
      for (int i = 0; i < 45; i++) begin
        tick();
        exp_v = model(n, ok, q1, img);
        checks++;
        if (obs !== exp_v) begin
          failures++;
          $display("FAIL random t=%0d ok=%0d q1=%0d n=%0d got=%b exp=%b", t, ok, q1, n, obs, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_fault();
    test_run_boot();
    test_pending();
    test_reset_rampdn();
    test_second_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
